// File: rtl/prio_rr_arbiter.sv
// Registered N-way request arbiter with fixed-priority and round-robin modes.
// The winner is presented on a valid/ready handshake as an index and as a
// one-hot vector. A grant stays stable until the consumer accepts it. When
// the consumer accepts and further requests are pending, the next winner
// loads on the same edge, so the arbiter can sustain one grant per cycle.
module prio_rr_arbiter #(
    parameter  int N  = 8,
    localparam int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          mode,
    input  logic          grant_ready,
    output logic          grant_valid,
    output logic [IW-1:0] grant_idx,
    output logic [N-1:0]  grant_onehot,
    output logic          any_req,
    output logic [IW-1:0] rr_ptr
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [IW-1:0] TOP_IDX = IW'(N - 1);

    state_t        r_state;
    state_t        w_state_next;
    logic          r_grant_valid;
    logic          w_valid_next;
    logic [IW-1:0] r_grant_idx;
    logic [IW-1:0] w_idx_next;
    logic [N-1:0]  r_grant_onehot;
    logic [N-1:0]  w_onehot_next;
    logic [IW-1:0] r_rr_ptr;
    logic [IW-1:0] w_ptr_upd;
    logic [IW-1:0] w_sel_ptr;
    logic [IW-1:0] w_scan_idx;
    logic [IW-1:0] w_win_idx;
    logic          w_win_found;
    logic [N-1:0]  w_win_onehot;
    logic          w_hs;

    // Accepted handshake; the arbiter only holds a grant while in GRANT.
    assign w_hs = (r_state == GRANT) && grant_ready;

    // Pointer after this edge: the served index drops to lowest priority in
    // round-robin mode. A back-to-back load must see this updated value.
    always_comb begin
        w_ptr_upd = r_rr_ptr;
        if (w_hs && mode) begin
            w_ptr_upd = (r_grant_idx == '0) ? TOP_IDX : (r_grant_idx - IW'(1));
        end
    end

    // Fixed priority is round-robin with the pointer pinned to the top index.
    assign w_sel_ptr = mode ? w_ptr_upd : TOP_IDX;

    // Circular descending scan from the effective pointer; the first set request wins.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_scan_idx  = w_sel_ptr;
        for (int k = 0; k < N; k++) begin
            if (!w_win_found && req[w_scan_idx]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_scan_idx;
            end
            w_scan_idx = (w_scan_idx == '0) ? TOP_IDX : (w_scan_idx - IW'(1));
        end
    end

    // One-hot decode of the selected winner. It is all zeros when nothing is requested.
    for (genvar gi = 0; gi < N; gi++) begin : g_onehot
        assign w_win_onehot[gi] = w_win_found && (w_win_idx == IW'(gi));
    end

    // Next-state and next-output logic: load in IDLE, hold or advance in GRANT.
    always_comb begin
        w_state_next  = r_state;
        w_valid_next  = r_grant_valid;
        w_idx_next    = r_grant_idx;
        w_onehot_next = r_grant_onehot;
        case (r_state)
            IDLE: begin
                if (w_win_found) begin
                    w_state_next  = GRANT;
                    w_valid_next  = 1'b1;
                    w_idx_next    = w_win_idx;
                    w_onehot_next = w_win_onehot;
                end
            end
            GRANT: begin
                if (w_hs) begin
                    if (w_win_found) begin
                        w_idx_next    = w_win_idx;
                        w_onehot_next = w_win_onehot;
                    end else begin
                        w_state_next  = IDLE;
                        w_valid_next  = 1'b0;
                        w_onehot_next = '0;
                    end
                end
            end
            default: begin
                w_state_next  = IDLE;
                w_valid_next  = 1'b0;
                w_onehot_next = '0;
            end
        endcase
    end

    // State and output registers. Reset drops any outstanding grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= IDLE;
            r_grant_valid  <= 1'b0;
            r_grant_idx    <= '0;
            r_grant_onehot <= '0;
            r_rr_ptr       <= TOP_IDX;
        end else begin
            r_state        <= w_state_next;
            r_grant_valid  <= w_valid_next;
            r_grant_idx    <= w_idx_next;
            r_grant_onehot <= w_onehot_next;
            r_rr_ptr       <= w_ptr_upd;
        end
    end

    assign grant_valid  = r_grant_valid;
    assign grant_idx    = r_grant_idx;
    assign grant_onehot = r_grant_onehot;
    assign rr_ptr       = r_rr_ptr;
    assign any_req      = |req;

endmodule

// File: tb/tb_prio_rr_arbiter.sv
// Directed bench for prio_rr_arbiter (N=8). Inputs change 1 time unit after
// each rising edge, and outputs are checked at the same point.
module tb_prio_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       mode;
    logic       grant_ready;
    logic       grant_valid;
    logic [2:0] grant_idx;
    logic [7:0] grant_onehot;
    logic       any_req;
    logic [2:0] rr_ptr;

    int n_checks = 0;
    int n_fail   = 0;

    prio_rr_arbiter #(.N(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .mode         (mode),
        .grant_ready  (grant_ready),
        .grant_valid  (grant_valid),
        .grant_idx    (grant_idx),
        .grant_onehot (grant_onehot),
        .any_req      (any_req),
        .rr_ptr       (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 8'hFF; mode = 1'b0; grant_ready = 1'b0;
        tick(); tick();
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", grant_valid); end
        n_checks++; if (grant_onehot !== 8'h00) begin n_fail++; $display("FAIL reset_onehot got %h exp 00", grant_onehot); end
        n_checks++; if (grant_idx !== 3'd0) begin n_fail++; $display("FAIL reset_idx got %0d exp 0", grant_idx); end
        n_checks++; if (rr_ptr !== 3'd7) begin n_fail++; $display("FAIL reset_ptr got %0d exp 7", rr_ptr); end
        rst = 1'b0; req = 8'h00;
        tick();
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b exp 0", grant_valid); end
        n_checks++; if (any_req !== 1'b0) begin n_fail++; $display("FAIL idle_any_req got %b exp 0", any_req); end
        // grant_ready while idle must be ignored
        grant_ready = 1'b1;
        tick();
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ready_valid got %b exp 0", grant_valid); end
        n_checks++; if (rr_ptr !== 3'd7) begin n_fail++; $display("FAIL idle_ready_ptr got %0d exp 7", rr_ptr); end
        $display("txn reset: valid=%b ptr=%0d", grant_valid, rr_ptr);
    endtask

    task automatic test_fixed_priority();
        logic [7:0] top;
        logic [7:0] pat;
        logic [7:0] exp_oh;
        mode = 1'b0; grant_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            top = 8'h01 << i;
            pat = top | ((top - 8'h01) & 8'hA5);
            req = pat;
            n_checks++; if (any_req !== 1'b1) begin n_fail++; $display("FAIL fixed_any_req got %b exp 1", any_req); end
            tick();
            exp_oh = top;
            n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL fixed_valid[%0d] got %b exp 1", i, grant_valid); end
            n_checks++; if (grant_idx !== 3'(i)) begin n_fail++; $display("FAIL fixed_idx req=%h got %0d exp %0d", pat, grant_idx, i); end
            n_checks++; if (grant_onehot !== exp_oh) begin n_fail++; $display("FAIL fixed_onehot req=%h got %h exp %h", pat, grant_onehot, exp_oh); end
            n_checks++; if (rr_ptr !== 3'd7) begin n_fail++; $display("FAIL fixed_ptr got %0d exp 7", rr_ptr); end
            $display("txn fixed: req=%h idx=%0d", pat, grant_idx);
        end
        req = 8'h00;
        tick();
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL fixed_drain_valid got %b exp 0", grant_valid); end
        n_checks++; if (grant_onehot !== 8'h00) begin n_fail++; $display("FAIL fixed_drain_onehot got %h exp 00", grant_onehot); end
        n_checks++; if (grant_idx !== 3'd0) begin n_fail++; $display("FAIL fixed_drain_idx got %0d exp 0", grant_idx); end
        n_checks++; if (rr_ptr !== 3'd7) begin n_fail++; $display("FAIL fixed_drain_ptr got %0d exp 7", rr_ptr); end
    endtask

    task automatic test_rr_rotation();
        int exp_seq [9] = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        mode = 1'b1; req = 8'hFF; grant_ready = 1'b1;
        for (int s = 0; s < 9; s++) begin
            tick();
            n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid step %0d got %b exp 1", s, grant_valid); end
            n_checks++; if (grant_idx !== 3'(exp_seq[s])) begin n_fail++; $display("FAIL rr_idx step %0d got %0d exp %0d", s, grant_idx, exp_seq[s]); end
            n_checks++; if (rr_ptr !== 3'(exp_seq[s])) begin n_fail++; $display("FAIL rr_ptr step %0d got %0d exp %0d", s, rr_ptr, exp_seq[s]); end
            $display("txn rr: step=%0d idx=%0d ptr=%0d", s, grant_idx, rr_ptr);
        end
        req = 8'h00;
        tick();
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL rr_drain_valid got %b exp 0", grant_valid); end
        n_checks++; if (rr_ptr !== 3'd6) begin n_fail++; $display("FAIL rr_drain_ptr got %0d exp 6", rr_ptr); end
    endtask

    task automatic test_backpressure();
        mode = 1'b1; req = 8'b0001_0100; grant_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b exp 1", c, grant_valid); end
            n_checks++; if (grant_idx !== 3'd4) begin n_fail++; $display("FAIL bp_idx cyc %0d got %0d exp 4", c, grant_idx); end
            n_checks++; if (grant_onehot !== 8'h10) begin n_fail++; $display("FAIL bp_onehot cyc %0d got %h exp 10", c, grant_onehot); end
        end
        // mode and req changes mid-grant leave the outstanding grant alone
        req = 8'b0000_0100; mode = 1'b0;
        tick();
        n_checks++; if (grant_idx !== 3'd4) begin n_fail++; $display("FAIL sticky_idx got %0d exp 4", grant_idx); end
        n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL sticky_valid got %b exp 1", grant_valid); end
        mode = 1'b1; grant_ready = 1'b1;
        tick();
        n_checks++; if (grant_idx !== 3'd2) begin n_fail++; $display("FAIL bp_next_idx got %0d exp 2", grant_idx); end
        n_checks++; if (rr_ptr !== 3'd3) begin n_fail++; $display("FAIL bp_next_ptr got %0d exp 3", rr_ptr); end
        $display("txn backpressure: idx=%0d ptr=%0d", grant_idx, rr_ptr);
        req = 8'h00;
        tick();
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain_valid got %b exp 0", grant_valid); end
        n_checks++; if (grant_idx !== 3'd2) begin n_fail++; $display("FAIL bp_drain_idx_hold got %0d exp 2", grant_idx); end
        n_checks++; if (rr_ptr !== 3'd1) begin n_fail++; $display("FAIL bp_drain_ptr got %0d exp 1", rr_ptr); end
    endtask

    task automatic test_rr_skip_wrap();
        mode = 1'b1; req = 8'b1000_0001; grant_ready = 1'b1;
        tick();
        n_checks++; if (grant_idx !== 3'd0) begin n_fail++; $display("FAIL wrap_first_idx got %0d exp 0", grant_idx); end
        n_checks++; if (grant_onehot !== 8'h01) begin n_fail++; $display("FAIL wrap_first_onehot got %h exp 01", grant_onehot); end
        tick();
        n_checks++; if (rr_ptr !== 3'd7) begin n_fail++; $display("FAIL wrap_ptr got %0d exp 7", rr_ptr); end
        n_checks++; if (grant_idx !== 3'd7) begin n_fail++; $display("FAIL wrap_second_idx got %0d exp 7", grant_idx); end
        n_checks++; if (grant_onehot !== 8'h80) begin n_fail++; $display("FAIL wrap_second_onehot got %h exp 80", grant_onehot); end
        $display("txn skip_wrap: idx=%0d ptr=%0d", grant_idx, rr_ptr);
        req = 8'h00;
        tick();
        n_checks++; if (rr_ptr !== 3'd6) begin n_fail++; $display("FAIL wrap_drain_ptr got %0d exp 6", rr_ptr); end
    endtask

    task automatic test_reset_mid_grant();
        mode = 1'b1; req = 8'b0010_0000; grant_ready = 1'b0;
        tick(); tick();
        n_checks++; if (grant_idx !== 3'd5) begin n_fail++; $display("FAIL mid_pre_idx got %0d exp 5", grant_idx); end
        n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b exp 1", grant_valid); end
        rst = 1'b1;
        tick();
        n_checks++; if (grant_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", grant_valid); end
        n_checks++; if (rr_ptr !== 3'd7) begin n_fail++; $display("FAIL mid_rst_ptr got %0d exp 7", rr_ptr); end
        n_checks++; if (grant_onehot !== 8'h00) begin n_fail++; $display("FAIL mid_rst_onehot got %h exp 00", grant_onehot); end
        rst = 1'b0;
        tick();
        n_checks++; if (grant_valid !== 1'b1) begin n_fail++; $display("FAIL mid_regrant_valid got %b exp 1", grant_valid); end
        n_checks++; if (grant_idx !== 3'd5) begin n_fail++; $display("FAIL mid_regrant_idx got %0d exp 5", grant_idx); end
        $display("txn reset_mid_grant: valid=%b idx=%0d", grant_valid, grant_idx);
    endtask

    initial begin
        rst = 1'b1; req = 8'h00; mode = 1'b0; grant_ready = 1'b0;
        test_reset();
        test_fixed_priority();
        test_rr_rotation();
        test_backpressure();
        test_rr_skip_wrap();
        test_reset_mid_grant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
